evac_path_walker: RTL and testbench

- Consumer side of the shortest-path solver. Accepts a solved route on the 3x3 evacuation grid: a 9-bit path cell mask, source, destination and distance.
- Replays the route as an ordered stream of single-cell moves over a valid/ready handshake.
- Feeds the guidance/indicator logic that lights one cell and direction per step, and flags malformed routes.

---
 rtl/evac_grid_pkg.sv | 17 +
 rtl/evac_next_cell.sv | 46 ++++
 rtl/evac_path_walker.sv | 177 +++++++++++++++++
 tb/tb_evac_path_walker.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/evac_grid_pkg.sv
// evac_grid_pkg: shared 3x3 evacuation grid constants, codes and walker state encoding
//   Used by the path walker, the shortest-path solver and the indicator driver.
//   Cell index = row*GRID_W + col; direction codes double as neighbour slot indices.
package evac_grid_pkg;
  localparam int GRID_W = 3;
  localparam int GRID_H = 3;
  localparam int CELLS  = GRID_W * GRID_H;
  localparam int IDX_W  = 4;
  localparam int DIST_W = 3;
  typedef enum logic [1:0] {DIR_N = 2'b00, DIR_E = 2'b01, DIR_S = 2'b10, DIR_W = 2'b11} dir_t;
  typedef enum logic [1:0] {ERR_RANGE = 2'b00, ERR_MASK = 2'b01, ERR_LEN = 2'b10, ERR_NO_NEXT = 2'b11} err_t;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WALK, S_DONE, S_ERROR} state_t;
  // One-hot mask for a cell; indices past the grid give an empty mask.
  function automatic logic [CELLS-1:0] cell_bit(input logic [IDX_W-1:0] c);
    return CELLS'(1) << c;
  endfunction
endpackage

// File: rtl/evac_next_cell.sv
// evac_next_cell: combinational choice of the next route cell from the current one
//   cur         : current cell
//   path_mask   : cells on the route
//   visited     : cells already entered
//   destination : end cell, preferred whenever it is a legal neighbour
//   found       : a legal neighbour exists
//   next, dir   : chosen cell and move direction (N, E, S, W priority otherwise)
module evac_next_cell
  import evac_grid_pkg::*;
(
  input  logic [IDX_W-1:0] cur,
  input  logic [CELLS-1:0] path_mask,
  input  logic [CELLS-1:0] visited,
  input  logic [IDX_W-1:0] destination,
  output logic             found,
  output logic [IDX_W-1:0] next,
  output logic [1:0]       dir
);
  logic [IDX_W-1:0] w_row, w_col;
  logic [IDX_W-1:0] w_nb [4];
  logic [3:0]       w_edge, w_cand, w_hit;
  assign w_row = cur / IDX_W'(GRID_W);
  assign w_col = cur % IDX_W'(GRID_W);
  assign w_nb[0] = cur - IDX_W'(GRID_W);
  assign w_nb[1] = cur + IDX_W'(1);
  assign w_nb[2] = cur + IDX_W'(GRID_W);
  assign w_nb[3] = cur - IDX_W'(1);
  // Grid-edge legality per direction {W,S,E,N}; no wrap between rows.
  assign w_edge = (cur < IDX_W'(CELLS)) ?
                  {w_col != '0, w_row != IDX_W'(GRID_H-1), w_col != IDX_W'(GRID_W-1), w_row != '0} : 4'b0;
  assign found = |w_cand;
  assign next  = w_nb[dir];
  always_comb begin
    w_cand = '0;
    w_hit  = '0;
    dir    = DIR_N;
    for (int d = 0; d < 4; d++) begin
      w_cand[d] = w_edge[d] && path_mask[w_nb[d]] && !visited[w_nb[d]];
      w_hit[d]  = w_cand[d] && (w_nb[d] == destination);
    end
    for (int d = 3; d >= 0; d--)
      if (w_cand[d]) dir = 2'(d);
    for (int d = 3; d >= 0; d--)
      if (w_hit[d]) dir = 2'(d);
  end
endmodule

// File: rtl/evac_path_walker.sv
// evac_path_walker: replays a solved 3x3 route as a stream of single-cell moves
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : route handshake (path_mask, source, destination, distance)
//   step_valid/ready    : move handshake (step_cell, step_dir, step_last)
//   done                : one-cycle pulse when the route completes
//   error, err_code     : sticky malformed-route flag and cause, cleared on next accept
//   EVAC_PATH_WALKER_FIRE_ABORT_EN adds fire_cells (live) and sticky fire_abort:
//   an offered move into a burning cell aborts the walk with NO_NEXT.
module evac_path_walker
  import evac_grid_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CELLS-1:0]  path_mask,
  input  logic [IDX_W-1:0]  source,
  input  logic [IDX_W-1:0]  destination,
  input  logic [DIST_W-1:0] distance,
`ifdef EVAC_PATH_WALKER_FIRE_ABORT_EN
  input  logic [CELLS-1:0]  fire_cells,
  output logic              fire_abort,
`endif
  output logic              step_valid,
  input  logic              step_ready,
  output logic [IDX_W-1:0]  step_cell,
  output logic [1:0]        step_dir,
  output logic              step_last,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);
  state_t            r_state;
  logic [CELLS-1:0]  r_mask, r_vis;
  logic [IDX_W-1:0]  r_src, r_dst, r_cur, r_step_cell;
  logic [DIST_W-1:0] r_dist;
  logic [1:0]        r_step_dir;
  logic              r_in_ready, r_step_valid, r_step_last, r_done, r_error;
  err_t              r_err_code;
  logic              w_found;
  logic [IDX_W-1:0]  w_next;
  logic [1:0]        w_dir;
`ifdef EVAC_PATH_WALKER_FIRE_ABORT_EN
  logic              r_fire_abort;
  assign fire_abort = r_fire_abort;
`endif
  assign in_ready   = r_in_ready;
  assign step_valid = r_step_valid;
  assign step_cell  = r_step_cell;
  assign step_dir   = r_step_dir;
  assign step_last  = r_step_last;
  assign done       = r_done;
  assign error      = r_error;
  assign err_code   = r_err_code;
  // r_cur is loaded with the source on accept, so the selector already
  // proposes the first move while the route is being checked.
  evac_next_cell u_next (
    .cur         (r_cur),
    .path_mask   (r_mask),
    .visited     (r_vis),
    .destination (r_dst),
    .found       (w_found),
    .next        (w_next),
    .dir         (w_dir)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_mask       <= '0;
      r_vis        <= '0;
      r_src        <= '0;
      r_dst        <= '0;
      r_cur        <= '0;
      r_dist       <= '0;
      r_in_ready   <= 1'b0;
      r_step_valid <= 1'b0;
      r_step_cell  <= '0;
      r_step_dir   <= '0;
      r_step_last  <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= ERR_RANGE;
`ifdef EVAC_PATH_WALKER_FIRE_ABORT_EN
      r_fire_abort <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= !(in_valid && r_in_ready);
          if (in_valid && r_in_ready) begin
            r_mask     <= path_mask;
            r_src      <= source;
            r_dst      <= destination;
            r_dist     <= distance;
            r_cur      <= source;
            r_vis      <= cell_bit(source);
            r_error    <= 1'b0;
            r_err_code <= ERR_RANGE;
`ifdef EVAC_PATH_WALKER_FIRE_ABORT_EN
            r_fire_abort <= 1'b0;
`endif
            r_state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_src >= IDX_W'(CELLS) || r_dst >= IDX_W'(CELLS)) begin
            r_error    <= 1'b1;
            r_err_code <= ERR_RANGE;
            r_state    <= S_ERROR;
          end else if (!r_mask[r_src] || !r_mask[r_dst]) begin
            r_error    <= 1'b1;
            r_err_code <= ERR_MASK;
            r_state    <= S_ERROR;
          end else if ($countones(r_mask) != int'(r_dist) + 1) begin
            r_error    <= 1'b1;
            r_err_code <= ERR_LEN;
            r_state    <= S_ERROR;
          end else if (r_src == r_dst) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (!w_found) begin
            r_error    <= 1'b1;
            r_err_code <= ERR_NO_NEXT;
            r_state    <= S_ERROR;
          end else begin
            r_step_valid <= 1'b1;
            r_step_cell  <= w_next;
            r_step_dir   <= w_dir;
            r_step_last  <= (w_next == r_dst);
            r_state      <= S_WALK;
          end
        end
        S_WALK: begin
`ifdef EVAC_PATH_WALKER_FIRE_ABORT_EN
          if (r_step_valid && fire_cells[r_step_cell]) begin
            r_step_valid <= 1'b0;
            r_error      <= 1'b1;
            r_err_code   <= ERR_NO_NEXT;
            r_fire_abort <= 1'b1;
            r_state      <= S_ERROR;
          end else
`endif
          if (r_step_valid) begin
            if (step_ready) begin
              r_step_valid         <= 1'b0;
              r_vis[r_step_cell]   <= 1'b1;
              r_cur                <= r_step_cell;
              if (r_step_last) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end
          end else if (w_found) begin
            r_step_valid <= 1'b1;
            r_step_cell  <= w_next;
            r_step_dir   <= w_dir;
            r_step_last  <= (w_next == r_dst);
          end else begin
            r_error    <= 1'b1;
            r_err_code <= ERR_NO_NEXT;
            r_state    <= S_ERROR;
          end
        end
        S_DONE: begin
          r_done     <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        S_ERROR: begin
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_evac_path_walker.sv
// tb_evac_path_walker: directed self-checking bench for evac_path_walker
module tb_evac_path_walker;
  import evac_grid_pkg::*;
  logic              clk = 1'b0, reset = 1'b1, in_valid = 1'b0, step_ready = 1'b0;
  logic [CELLS-1:0]  path_mask = '0;
  logic [IDX_W-1:0]  source = '0, destination = '0;
  logic [DIST_W-1:0] distance = '0;
  logic              in_ready, step_valid, step_last, done, error;
  logic [IDX_W-1:0]  step_cell;
  logic [1:0]        step_dir, err_code;
`ifdef EVAC_PATH_WALKER_FIRE_ABORT_EN
  logic [CELLS-1:0]  fire_cells = '0;
  logic              fire_abort;
`endif
  int checks = 0, errors = 0;
  logic [IDX_W-1:0] exp_cell [4] = '{4'd1, 4'd2, 4'd5, 4'd8};
  logic [1:0]       exp_dir  [4] = '{2'd1, 2'd1, 2'd2, 2'd2};
  evac_path_walker dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .path_mask   (path_mask),
    .source      (source),
    .destination (destination),
    .distance    (distance),
`ifdef EVAC_PATH_WALKER_FIRE_ABORT_EN
    .fire_cells  (fire_cells),
    .fire_abort  (fire_abort),
`endif
    .step_valid  (step_valid),
    .step_ready  (step_ready),
    .step_cell   (step_cell),
    .step_dir    (step_dir),
    .step_last   (step_last),
    .done        (done),
    .error       (error),
    .err_code    (err_code)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [CELLS-1:0] m, input logic [IDX_W-1:0] s, input logic [IDX_W-1:0] d,
                      input logic [DIST_W-1:0] n);
    int w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("send_in_ready", 32'(in_ready), 1);
    path_mask = m;
    source = s;
    destination = d;
    distance = n;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic take_steps(input int first, input int count, input int stall);
    for (int k = first; k < first + count; k++) begin
      int w = 0;
      while (!step_valid && w < 10) begin
        @(negedge clk);
        w++;
      end
      chk("step_valid", 32'(step_valid), 1);
      chk("step_cell", 32'(step_cell), 32'(exp_cell[k]));
      chk("step_dir", 32'(step_dir), 32'(exp_dir[k]));
      chk("step_last", 32'(step_last), 32'(k == 3));
      for (int i = 0; i < ((k == first) ? stall : 0); i++) begin
        @(negedge clk);
        chk("stall_valid", 32'(step_valid), 1);
        chk("stall_cell", 32'(step_cell), 32'(exp_cell[k]));
        chk("stall_dir", 32'(step_dir), 32'(exp_dir[k]));
      end
      step_ready = 1'b1;
      @(negedge clk);
      step_ready = 1'b0;
      if (k < 3) begin
        chk("gap_valid", 32'(step_valid), 0);
        chk("gap_done", 32'(done), 0);
      end else
        chk("done_pulse", 32'(done), 1);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_step_valid", 32'(step_valid), 0);
    chk("rst_step_cell", 32'(step_cell), 0);
    chk("rst_step_dir", 32'(step_dir), 0);
    chk("rst_step_last", 32'(step_last), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_err_code", 32'(err_code), 0);
    reset = 1'b0;
    // Route 0 -> 1 -> 2 -> 5 -> 8
    send(9'b100100111, 4'd0, 4'd8, 3'd4);
    chk("c1_check_valid", 32'(step_valid), 0);
    take_steps(0, 4, 0);
    @(negedge clk);
    chk("c1_done_clear", 32'(done), 0);
    chk("c1_error", 32'(error), 0);
    // Source equals destination: immediate done, no moves
    send(9'b000010000, 4'd4, 4'd4, 3'd0);
    chk("c2_check_done", 32'(done), 0);
    @(negedge clk);
    chk("c2_done", 32'(done), 1);
    chk("c2_step_valid", 32'(step_valid), 0);
    @(negedge clk);
    chk("c2_done_clear", 32'(done), 0);
    chk("c2_in_ready", 32'(in_ready), 1);
    chk("c2_step_valid2", 32'(step_valid), 0);
    // Destination not on mask
    send(9'b000001111, 4'd0, 4'd8, 3'd4);
    chk("c3_check_error", 32'(error), 0);
    @(negedge clk);
    chk("c3_error", 32'(error), 1);
    chk("c3_err_code", 32'(err_code), 1);
    chk("c3_in_ready_busy", 32'(in_ready), 0);
    chk("c3_step_valid", 32'(step_valid), 0);
    @(negedge clk);
    chk("c3_in_ready", 32'(in_ready), 1);
    chk("c3_error_sticky", 32'(error), 1);
    // Route 1 with the first move back-pressured
    send(9'b100100111, 4'd0, 4'd8, 3'd4);
    chk("c4_error_cleared", 32'(error), 0);
    chk("c4_err_code_cleared", 32'(err_code), 0);
    take_steps(0, 4, 5);
    @(negedge clk);
    chk("c4_done_clear", 32'(done), 0);
    // Reset mid-walk after the second move
    send(9'b100100111, 4'd0, 4'd8, 3'd4);
    take_steps(0, 2, 0);
    #2 reset = 1'b1;
    #1;
    chk("c5_in_ready", 32'(in_ready), 0);
    chk("c5_step_valid", 32'(step_valid), 0);
    chk("c5_step_cell", 32'(step_cell), 0);
    chk("c5_step_dir", 32'(step_dir), 0);
    chk("c5_done", 32'(done), 0);
    chk("c5_error", 32'(error), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("c5_no_done", 32'(done), 0);
    end
    reset = 1'b0;
    send(9'b100100111, 4'd0, 4'd8, 3'd4);
    take_steps(0, 4, 0);
    @(negedge clk);
    chk("c5_done_clear", 32'(done), 0);
`ifdef EVAC_PATH_WALKER_FIRE_ABORT_EN
    // Cell 5 burning: abort when the move into it is offered
    fire_cells = 9'b000100000;
    send(9'b100100111, 4'd0, 4'd8, 3'd4);
    take_steps(0, 2, 0);
    @(negedge clk);
    chk("c6_offer_valid", 32'(step_valid), 1);
    chk("c6_offer_cell", 32'(step_cell), 5);
    @(negedge clk);
    chk("c6_valid_dropped", 32'(step_valid), 0);
    chk("c6_error", 32'(error), 1);
    chk("c6_err_code", 32'(err_code), 3);
    chk("c6_fire_abort", 32'(fire_abort), 1);
    @(negedge clk);
    chk("c6_in_ready", 32'(in_ready), 1);
    chk("c6_fire_abort_sticky", 32'(fire_abort), 1);
    fire_cells = '0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
